ddr_request_arbiter: RTL and testbench
======================================

# ddr_request_arbiter

Shares the single client port of the DDR memory interface among `NUM_PORTS` requesters (CPU, DMA, video, …) in the system clock domain. Selects one pending request per transaction with round-robin arbitration, then sequences it. A transaction is one command pulse, `BURST_LEN` write-data pushes or read-data pulls, and a done pulse. The block sits between the SoC bus adapters and the memory interface's `address_i`/`write_i`/`read_i`/`push_i`/`pull_i`/`done_i` side.

## Interface
- `NUM_PORTS`, 4 — number of requesters, 2..8.
- `BURST_LEN`, 2 — 64-bit beats per transaction, 1..8.
- `clk_i` in 1 — system clock; the only clock.
- `rst_i` in 1 — asynchronous, active-high reset.
- `req_valid_i` in NUM_PORTS — per-port request pending; held until the grant pulse.
- `req_write_i` in NUM_PORTS — per-port type: 1 = write, 0 = read.
- `req_address_i` in NUM_PORTS*27 — per-port DRAM address, flattened; port k is bits [27k+26:27k].
- `req_wdata_i` in NUM_PORTS*64 — per-port current write beat.
- `req_wmask_i` in NUM_PORTS*8 — per-port byte enables; 1 = byte written.
- `req_grant_o` out NUM_PORTS — one-hot, one-cycle pulse when the request is accepted.
- `req_wack_o` out NUM_PORTS — one-hot pulse marking a beat consumed; the requester advances to the next beat.
- `rsp_valid_o` out NUM_PORTS — one-hot pulse marking a read beat on `rsp_data_o`.
- `rsp_data_o` out 64 — read beat, shared by all ports.
- `rsp_done_o` out NUM_PORTS — one-hot pulse at the end of the transaction.
- `mem_ready_i` in 1 — memory interface ready (calibrated).
- `mem_address_o` out 27 — command address.
- `mem_write_o`, `mem_read_o` out 1 — command pulses.
- `mem_push_o` out 1 — write-data push.
- `mem_write_data_o` out 64 — write beat to the memory interface.
- `mem_write_mask_o` out 8 — byte enables to the memory interface.
- `mem_pull_o` out 1 — read-data pull.
- `mem_read_data_i` in 64 — read beat; first-word-fall-through, valid in the cycle `mem_pull_o` is high.
- `mem_read_valid_i` in 1 — read data available.
- `mem_done_o` out 1 — transaction-complete pulse to the memory interface.

## Operation
- FSM states: IDLE, CMD, WRITE, READ, DONE.
- **IDLE.** If `mem_ready_i` is high and any `req_valid_i` is set, pick winner w and register w, its type and its address, then go to CMD. Otherwise stay.
- **Round-robin.** Search starts at `rr_ptr`, wrapping modulo `NUM_PORTS`. After DONE, `rr_ptr` = (w+1) mod `NUM_PORTS`.
- **CMD**, one cycle:
  - `mem_write_o` or `mem_read_o` = 1, `mem_address_o` = registered address.
  - `req_grant_o[w]` = 1.
  - Beat counter cleared.
  - Next state is WRITE or READ.
- **WRITE.**
  - Each cycle: `mem_push_o` = 1, `mem_write_data_o`/`mem_write_mask_o` = port w's `req_wdata_i`/`req_wmask_i`, `req_wack_o[w]` = 1, counter++.
  - After `BURST_LEN` beats, go to DONE.
- **READ.**
  - In each cycle with `mem_read_valid_i` = 1: `mem_pull_o` = 1, `rsp_data_o` = `mem_read_data_i`, `rsp_valid_o[w]` = 1, counter++.
  - In a cycle with `mem_read_valid_i` = 0: stall with no pull.
  - After `BURST_LEN` pulls, go to DONE.
- **DONE**, one cycle: `mem_done_o` = 1, `rsp_done_o[w]` = 1, update `rr_ptr`, go to IDLE.
- The beat counter is `$clog2(BURST_LEN)+1` bits. Completion is the compare counter == `BURST_LEN`-1 in a beat-transfer cycle.
- **Withdrawn request.** Dropping `req_valid_i` before the grant withdraws the request. After the grant the request is committed regardless of `req_valid_i`.
- **`mem_ready_i` low.** While in IDLE, no new grant is issued. Once past IDLE, the transaction completes normally.
- **Simultaneous requests.** Exactly one grant per transaction. Non-granted ports keep waiting, with no starvation: a waiting port is served within `NUM_PORTS`-1 transactions.

## Timing
- **Reset values.** `rst_i` asserted at any time clears all outputs to 0, state to IDLE, `rr_ptr` to 0 and the counter to 0.
- **Reset mid-transaction.** An in-flight transaction is abandoned with no done pulse.
- **Outputs.** All outputs are registered-state decodes with no combinational path from `req_*`. Exception: `mem_write_data_o`, `mem_write_mask_o` and `rsp_data_o` are muxes of the inputs.
- **Request to grant.** `req_valid_i` seen in cycle t (IDLE) gives the grant/command pulse at t+1.
- **Write latency.** Beats at t+2 .. t+1+`BURST_LEN`, done pulse at t+2+`BURST_LEN`, IDLE at t+3+`BURST_LEN`.
- **Read latency.** Same as write when `mem_read_valid_i` is continuously high; each low cycle adds one.
- **Throughput.** Minimum transaction length is `BURST_LEN`+3 cycles, IDLE included.

## Configuration
- `DDR_ARBITER_FIXED_PRIORITY_EN`.
- Defined: fixed priority; the lowest-index valid port always wins, and `rr_ptr` is removed.
- Undefined (default): round-robin as specified above.

## Test plan
- **Single write.** Reset, `mem_ready_i`=1, port 0 write at 0x0000100 with beats 0xA..A1, 0xA..A2 and mask 0xFF → grant pulse, `mem_write_o` with address 0x0000100, two pushes with those beats and `req_wack_o`=0001, then `mem_done_o` and `rsp_done_o`=0001, all within 5 cycles.
- **Read with stall.** Port 2 read at 0x1234567, `mem_read_valid_i` low for 3 cycles then high → `mem_read_o`, no pull for those 3 cycles, then 2 pulls with `rsp_valid_o`=0100 carrying `mem_read_data_i`, then done.
- **Round-robin fairness.** All 4 ports hold reads → grant order 0,1,2,3,0. With `DDR_ARBITER_FIXED_PRIORITY_EN` defined → port 0 granted every time.
- **Not ready.** `mem_ready_i`=0 with port 1 valid for 10 cycles → no grant. Raise `mem_ready_i` → grant at the next cycle.
- **Reset mid-write.** Assert `rst_i` after the first push → all outputs 0 immediately, no `mem_done_o`, next request starts its search at port 0.
- **Withdrawn request.** Port 3 drops `req_valid_i` while port 1 is mid-transaction → port 3 is never granted, and it raises no `req_wack_o`, `rsp_valid_o` or `rsp_done_o` bits.

Source files
------------

// File: rtl/ddr_request_arbiter.sv
// Shares the DDR client port among NUM_PORTS requesters, one burst per grant.
// Round-robin by default; DDR_ARBITER_FIXED_PRIORITY_EN selects lowest-index-wins.
module ddr_request_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int BURST_LEN = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_PORTS-1:0]    req_valid_i,
  input  logic [NUM_PORTS-1:0]    req_write_i,
  input  logic [NUM_PORTS*27-1:0] req_address_i,
  input  logic [NUM_PORTS*64-1:0] req_wdata_i,
  input  logic [NUM_PORTS*8-1:0]  req_wmask_i,
  output logic [NUM_PORTS-1:0]    req_grant_o,
  output logic [NUM_PORTS-1:0]    req_wack_o,
  output logic [NUM_PORTS-1:0]    rsp_valid_o,
  output logic [63:0]             rsp_data_o,
  output logic [NUM_PORTS-1:0]    rsp_done_o,
  input  logic                    mem_ready_i,
  output logic [26:0]             mem_address_o,
  output logic                    mem_write_o,
  output logic                    mem_read_o,
  output logic                    mem_push_o,
  output logic [63:0]             mem_write_data_o,
  output logic [7:0]              mem_write_mask_o,
  output logic                    mem_pull_o,
  input  logic [63:0]             mem_read_data_i,
  input  logic                    mem_read_valid_i,
  output logic                    mem_done_o,
  output logic [2:0]              dbg_state_o
);

  // Handshake: a requester holds req_valid_i until its one-cycle req_grant_o;
  // after that the transaction is committed and req_valid_i is ignored.
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = $clog2(BURST_LEN) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state;
  logic [PW-1:0] win;
  logic          win_write;
  logic [26:0]   win_addr;
  logic [CW-1:0] cnt;
  logic [PW-1:0] pick;
  logic          xfer;

  logic [26:0] addr_arr  [NUM_PORTS];
  logic [63:0] wdata_arr [NUM_PORTS];
  logic [7:0]  wmask_arr [NUM_PORTS];

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      addr_arr[i]  = req_address_i[i*27 +: 27];
      wdata_arr[i] = req_wdata_i[i*64 +: 64];
      wmask_arr[i] = req_wmask_i[i*8 +: 8];
    end
  end

`ifdef DDR_ARBITER_FIXED_PRIORITY_EN
  always_comb begin
    pick = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req_valid_i[i]) pick = PW'(i);
    end
  end
`else
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] idx;

  // Scan from the far end back toward rr_ptr so the nearest valid port wins.
  always_comb begin
    pick = '0;
    idx  = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      idx = PW'((int'(rr_ptr) + i) % NUM_PORTS);
      if (req_valid_i[idx]) pick = idx;
    end
  end
`endif

  assign xfer        = (state == S_WRITE) || ((state == S_READ) && mem_read_valid_i);
  assign dbg_state_o = state;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      win       <= '0;
      win_write <= 1'b0;
      win_addr  <= '0;
      cnt       <= '0;
`ifndef DDR_ARBITER_FIXED_PRIORITY_EN
      rr_ptr    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_ready_i && (|req_valid_i)) begin
            win       <= pick;
            win_write <= req_write_i[pick];
            win_addr  <= addr_arr[pick];
            state     <= S_CMD;
          end
        end
        S_CMD: begin
          cnt   <= '0;
          state <= win_write ? S_WRITE : S_READ;
        end
        S_WRITE, S_READ: begin
          if (xfer) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_BEAT) state <= S_DONE;
          end
        end
        S_DONE: begin
`ifndef DDR_ARBITER_FIXED_PRIORITY_EN
          rr_ptr <= (int'(win) == NUM_PORTS - 1) ? '0 : win + 1'b1;
`endif
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Every output is a decode of registered state; only the data buses mux inputs.
  always_comb begin
    req_grant_o      = '0;
    req_wack_o       = '0;
    rsp_valid_o      = '0;
    rsp_done_o       = '0;
    rsp_data_o       = '0;
    mem_address_o    = '0;
    mem_write_o      = 1'b0;
    mem_read_o       = 1'b0;
    mem_push_o       = 1'b0;
    mem_write_data_o = '0;
    mem_write_mask_o = '0;
    mem_pull_o       = 1'b0;
    mem_done_o       = 1'b0;
    case (state)
      S_CMD: begin
        mem_write_o      = win_write;
        mem_read_o       = ~win_write;
        mem_address_o    = win_addr;
        req_grant_o[win] = 1'b1;
      end
      S_WRITE: begin
        mem_push_o       = 1'b1;
        mem_write_data_o = wdata_arr[win];
        mem_write_mask_o = wmask_arr[win];
        req_wack_o[win]  = 1'b1;
      end
      S_READ: begin
        if (mem_read_valid_i) begin
          mem_pull_o       = 1'b1;
          rsp_data_o       = mem_read_data_i;
          rsp_valid_o[win] = 1'b1;
        end
      end
      S_DONE: begin
        mem_done_o      = 1'b1;
        rsp_done_o[win] = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ddr_request_arbiter.sv
// Bench for ddr_request_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level arbitration model.
`timescale 1ns/1ps
module tb_ddr_request_arbiter;
  localparam int N  = 4;
  localparam int BL = 2;
  localparam int M_IDLE  = 0;
  localparam int M_GRANT = 1;
  localparam int M_BEAT  = 2;
  localparam int M_DONE  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_write;
  logic [N*27-1:0] req_address;
  logic [N*64-1:0] req_wdata;
  logic [N*8-1:0]  req_wmask;
  logic [N-1:0]  req_grant, req_wack, rsp_valid, rsp_done;
  logic [63:0]   rsp_data;
  logic          mem_ready;
  logic [26:0]   mem_address;
  logic          mem_write, mem_read, mem_push, mem_pull, mem_done;
  logic [63:0]   mem_write_data;
  logic [7:0]    mem_write_mask;
  logic [63:0]   mem_read_data;
  logic          mem_read_valid;
  logic [2:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  int rr_model = 0;

  logic [20:0] obs_ctl;
  assign obs_ctl = {req_grant, req_wack, rsp_valid, rsp_done,
                    mem_write, mem_read, mem_push, mem_pull, mem_done};

  always #5 clk = ~clk;

  ddr_request_arbiter #(.NUM_PORTS(N), .BURST_LEN(BL)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_write_i(req_write), .req_address_i(req_address),
    .req_wdata_i(req_wdata), .req_wmask_i(req_wmask),
    .req_grant_o(req_grant), .req_wack_o(req_wack), .rsp_valid_o(rsp_valid),
    .rsp_data_o(rsp_data), .rsp_done_o(rsp_done),
    .mem_ready_i(mem_ready), .mem_address_o(mem_address),
    .mem_write_o(mem_write), .mem_read_o(mem_read), .mem_push_o(mem_push),
    .mem_write_data_o(mem_write_data), .mem_write_mask_o(mem_write_mask),
    .mem_pull_o(mem_pull), .mem_read_data_i(mem_read_data),
    .mem_read_valid_i(mem_read_valid), .mem_done_o(mem_done),
    .dbg_state_o(dbg_state)
  );

  // Reference arbitration rule: first valid port at or after ptr (or lowest index).
  function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
    int r;
    r = -1;
`ifdef DDR_ARBITER_FIXED_PRIORITY_EN
    for (int i = 0; i < N; i++) if (v[i] && r < 0) r = i;
`else
    for (int i = 0; i < N; i++) if (v[(ptr + i) % N] && r < 0) r = (ptr + i) % N;
`endif
    return r;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic v, input logic w, input logic [26:0] a,
                          input logic [63:0] d, input logic [7:0] m);
    req_valid[p] = v;
    req_write[p] = w;
    req_address[p*27 +: 27] = a;
    req_wdata[p*64 +: 64] = d;
    req_wmask[p*8 +: 8] = m;
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_write = '0; req_address = '0; req_wdata = '0; req_wmask = '0;
    mem_read_data = '0; mem_read_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    mem_ready = 1'b1;
    rst = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++;
    if (obs_ctl !== '0 || mem_address !== '0 || mem_write_data !== '0 ||
        mem_write_mask !== '0 || rsp_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs ctl=%h addr=%h wdata=%h expected all zero", obs_ctl, mem_address, mem_write_data);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    rr_model = 0;
  endtask

  task automatic test_single_write();
    logic [63:0] wb [2];
    logic [20:0] exp_c [6];
    int bidx;
    wb[0] = 64'hAAAA_AAAA_AAAA_AAA1;
    wb[1] = 64'hAAAA_AAAA_AAAA_AAA2;
    exp_c[0] = '0;
    exp_c[1] = {4'b0001, 12'b0, 5'b10000};
    exp_c[2] = {4'b0000, 4'b0001, 8'b0, 5'b00100};
    exp_c[3] = exp_c[2];
    exp_c[4] = {12'b0, 4'b0001, 5'b00001};
    exp_c[5] = '0;
    bidx = 0;
    for (int c = 0; c < 6; c++) begin
      set_port(0, c <= 1, 1'b1, 27'h0000100, wb[(bidx > 1) ? 1 : bidx], 8'hFF);
      @(negedge clk);
      checks++;
      if (obs_ctl !== exp_c[c]) begin
        errors++;
        $display("FAIL single_write_ctl c=%0d got=%h exp=%h", c, obs_ctl, exp_c[c]);
      end
      if (c == 1) begin
        checks++;
        if (mem_address !== 27'h0000100) begin
          errors++;
          $display("FAIL single_write_addr got=%h exp=%h", mem_address, 27'h0000100);
        end
      end
      if (c == 2 || c == 3) begin
        checks++;
        if (mem_write_data !== wb[c-2] || mem_write_mask !== 8'hFF) begin
          errors++;
          $display("FAIL single_write_beat c=%0d got=%h/%h exp=%h/ff", c, mem_write_data, mem_write_mask, wb[c-2]);
        end
      end
      if (req_wack[0]) bidx++;
      next_cycle();
    end
    rr_model = 1;
  endtask

  task automatic test_read_stall();
    logic [20:0] exp_c [9];
    logic [63:0] d;
    exp_c[0] = '0;
    exp_c[1] = {4'b0100, 12'b0, 5'b01000};
    exp_c[2] = '0; exp_c[3] = '0; exp_c[4] = '0;
    exp_c[5] = {8'b0, 4'b0100, 4'b0, 5'b00010};
    exp_c[6] = exp_c[5];
    exp_c[7] = {12'b0, 4'b0100, 5'b00001};
    exp_c[8] = '0;
    for (int c = 0; c < 9; c++) begin
      set_port(2, c <= 1, 1'b0, 27'h1234567, '0, '0);
      d = {$urandom, $urandom};
      mem_read_data = d;
      mem_read_valid = (c >= 5);
      @(negedge clk);
      checks++;
      if (obs_ctl !== exp_c[c]) begin
        errors++;
        $display("FAIL read_stall_ctl c=%0d got=%h exp=%h", c, obs_ctl, exp_c[c]);
      end
      if (c == 1) begin
        checks++;
        if (mem_address !== 27'h1234567) begin
          errors++;
          $display("FAIL read_stall_addr got=%h exp=%h", mem_address, 27'h1234567);
        end
      end
      if (c == 5 || c == 6) begin
        checks++;
        if (rsp_data !== d) begin
          errors++;
          $display("FAIL read_stall_data c=%0d got=%h exp=%h", c, rsp_data, d);
        end
      end
      next_cycle();
    end
    idle_inputs();
    rr_model = 3;
  endtask

  task automatic test_round_robin();
    int grants, dones, w;
    logic [N-1:0] exp_g;
    test_reset();
    grants = 0;
    dones = 0;
    for (int c = 0; c < 60 && dones < 5; c++) begin
      req_valid = (grants < 5) ? {N{1'b1}} : '0;
      req_write = '0;
      mem_read_valid = 1'b1;
      mem_read_data = {$urandom, $urandom};
      @(negedge clk);
      if (req_grant !== '0) begin
        w = rr_pick({N{1'b1}}, rr_model);
        exp_g = N'(1) << w;
        checks++;
        if (req_grant !== exp_g) begin
          errors++;
          $display("FAIL rr_order n=%0d got=%b exp=%b", grants, req_grant, exp_g);
        end
        rr_model = (w + 1) % N;
        grants++;
      end
      if (rsp_done !== '0) dones++;
      next_cycle();
    end
    checks++;
    if (grants != 5 || dones != 5) begin
      errors++;
      $display("FAIL rr_budget grants=%0d dones=%0d exp=5/5", grants, dones);
    end
    idle_inputs();
  endtask

  task automatic test_not_ready();
    int dones;
    mem_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      set_port(1, 1'b1, 1'b0, 27'h0ABCDEF, '0, '0);
      mem_ready = (c == 10);
      @(negedge clk);
      checks++;
      if (c < 11 && obs_ctl !== '0) begin
        errors++;
        $display("FAIL not_ready_idle c=%0d got=%h exp=0", c, obs_ctl);
      end else if (c == 11 && obs_ctl !== {4'b0010, 12'b0, 5'b01000}) begin
        errors++;
        $display("FAIL not_ready_grant got=%h exp=%h", obs_ctl, {4'b0010, 12'b0, 5'b01000});
      end
      next_cycle();
    end
    idle_inputs();
    mem_read_valid = 1'b1;
    dones = 0;
    for (int c = 0; c < 10 && dones == 0; c++) begin
      @(negedge clk);
      if (rsp_done[1]) dones++;
      next_cycle();
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL not_ready_completion done=%0d exp=1", dones);
    end
    mem_ready = 1'b1;
    idle_inputs();
    rr_model = 2;
  endtask

  task automatic test_reset_mid_write();
    int dones;
    logic [N-1:0] exp_g;
    for (int c = 0; c < 3; c++) begin
      set_port(0, c <= 1, 1'b1, 27'h0000040, 64'h1111_2222_3333_4444, 8'h0F);
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if (req_grant !== 4'b0001) begin
          errors++;
          $display("FAIL midrst_grant got=%b exp=0001", req_grant);
        end
      end
      if (c == 2) begin
        checks++;
        if (req_wack !== 4'b0001 || mem_push !== 1'b1) begin
          errors++;
          $display("FAIL midrst_push got=%b/%b exp=0001/1", req_wack, mem_push);
        end
      end
      if (c < 2) next_cycle();
    end
    rst = 1'b1;
    #1;
    checks++;
    if (obs_ctl !== '0 || mem_write_data !== '0 || mem_write_mask !== '0) begin
      errors++;
      $display("FAIL midrst_immediate ctl=%h wdata=%h exp=0", obs_ctl, mem_write_data);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
    rst = 1'b0;
    rr_model = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (obs_ctl !== '0) begin
        errors++;
        $display("FAIL midrst_quiet c=%0d got=%h exp=0", c, obs_ctl);
      end
      next_cycle();
    end
    exp_g = N'(1) << rr_pick(4'b1010, rr_model);
    for (int c = 0; c < 2; c++) begin
      set_port(1, c == 0 || c == 1, 1'b0, 27'h0000200, '0, '0);
      set_port(3, c == 0 || c == 1, 1'b0, 27'h0000300, '0, '0);
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if (req_grant !== exp_g) begin
          errors++;
          $display("FAIL midrst_rr_restart got=%b exp=%b", req_grant, exp_g);
        end
      end
      next_cycle();
    end
    idle_inputs();
    mem_read_valid = 1'b1;
    dones = 0;
    for (int c = 0; c < 10 && dones == 0; c++) begin
      @(negedge clk);
      if (rsp_done !== '0) dones++;
      next_cycle();
    end
    idle_inputs();
    rr_model = 2;
  endtask

  task automatic test_withdrawn();
    int dones;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      set_port(1, c <= 1, 1'b1, 27'h0000500, {$urandom, $urandom}, 8'hFF);
      set_port(3, c == 2 || c == 3, 1'b0, 27'h0000700, '0, '0);
      @(negedge clk);
      checks++;
      if ({req_grant[3], req_wack[3], rsp_valid[3], rsp_done[3]} !== 4'b0) begin
        errors++;
        $display("FAIL withdrawn_port3 c=%0d got=%b exp=0000",
                 c, {req_grant[3], req_wack[3], rsp_valid[3], rsp_done[3]});
      end
      if (c == 1) begin
        checks++;
        if (req_grant !== 4'b0010) begin
          errors++;
          $display("FAIL withdrawn_grant got=%b exp=0010", req_grant);
        end
      end
      if (rsp_done[1]) dones++;
      next_cycle();
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL withdrawn_port1_done got=%0d exp=1", dones);
    end
    idle_inputs();
    rr_model = 2;
  endtask

  // Randomized traffic scored against a transaction-level model.
  logic [63:0] r_beats [N][BL];
  logic [26:0] r_addr  [N];
  logic        r_write [N];
  logic [7:0]  r_mask  [N];
  int          bidx    [N];
  bit          pending [N];
  bit          busy    [N];
  int          skipped [N];

  task automatic test_random();
    int ph, w, beat_i, txns;
    logic [N-1:0] vvec, oh;
    logic [20:0]  exp_ctl;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    rr_model = 0;
    for (int p = 0; p < N; p++) begin
      pending[p] = 0; busy[p] = 0; bidx[p] = 0; skipped[p] = 0;
    end
    ph = M_IDLE; w = 0; beat_i = 0; txns = 0;
    for (int c = 0; c < 800; c++) begin
      mem_ready = ($urandom_range(0, 3) != 0);
      mem_read_valid = $urandom_range(0, 1);
      mem_read_data = {$urandom, $urandom};
      for (int p = 0; p < N; p++) begin
        if (!pending[p] && !busy[p] && $urandom_range(0, 2) == 0) begin
          pending[p] = 1;
          bidx[p] = 0;
          r_write[p] = $urandom_range(0, 1);
          r_addr[p] = 27'($urandom);
          r_mask[p] = 8'($urandom);
          for (int b = 0; b < BL; b++) r_beats[p][b] = {$urandom, $urandom};
        end else if (pending[p] && !busy[p] && ph != M_IDLE && $urandom_range(0, 15) == 0) begin
          pending[p] = 0;
          skipped[p] = 0;
        end
        set_port(p, pending[p], r_write[p], r_addr[p],
                 r_beats[p][(bidx[p] < BL) ? bidx[p] : BL-1], r_mask[p]);
      end
      vvec = req_valid;
      @(negedge clk);
      oh = N'(1) << w;
      exp_ctl = '0;
      case (ph)
        M_GRANT: exp_ctl = {oh, 12'b0, r_write[w], ~r_write[w], 3'b000};
        M_BEAT: begin
          if (r_write[w]) exp_ctl = {4'b0, oh, 8'b0, 5'b00100};
          else if (mem_read_valid) exp_ctl = {8'b0, oh, 4'b0, 5'b00010};
        end
        M_DONE: exp_ctl = {12'b0, oh, 5'b00001};
        default: exp_ctl = '0;
      endcase
      checks++;
      if (obs_ctl !== exp_ctl) begin
        errors++;
        $display("FAIL random_ctl c=%0d got=%h exp=%h", c, obs_ctl, exp_ctl);
      end
      if (ph == M_GRANT) begin
        checks++;
        if (mem_address !== r_addr[w]) begin
          errors++;
          $display("FAIL random_addr c=%0d got=%h exp=%h", c, mem_address, r_addr[w]);
        end
      end
      if (ph == M_BEAT && r_write[w]) begin
        checks++;
        if (mem_write_data !== r_beats[w][beat_i] || mem_write_mask !== r_mask[w]) begin
          errors++;
          $display("FAIL random_wbeat c=%0d got=%h/%h exp=%h/%h", c, mem_write_data, mem_write_mask,
                   r_beats[w][beat_i], r_mask[w]);
        end
      end
      if (ph == M_BEAT && !r_write[w] && mem_read_valid) begin
        checks++;
        if (rsp_data !== mem_read_data) begin
          errors++;
          $display("FAIL random_rdata c=%0d got=%h exp=%h", c, rsp_data, mem_read_data);
        end
      end
      case (ph)
        M_IDLE: begin
          if (mem_ready && (|vvec)) begin
            w = rr_pick(vvec, rr_model);
            busy[w] = 1;
            for (int p = 0; p < N; p++) begin
              if (p == w) skipped[p] = 0;
              else if (vvec[p]) begin
                skipped[p]++;
`ifndef DDR_ARBITER_FIXED_PRIORITY_EN
                checks++;
                if (skipped[p] > N - 1) begin
                  errors++;
                  $display("FAIL random_starvation port=%0d skipped=%0d max=%0d", p, skipped[p], N - 1);
                end
`endif
              end
            end
            ph = M_GRANT;
          end
        end
        M_GRANT: begin
          pending[w] = 0;
          beat_i = 0;
          ph = M_BEAT;
        end
        M_BEAT: begin
          if (r_write[w] || mem_read_valid) begin
            beat_i++;
            if (r_write[w]) bidx[w]++;
            if (beat_i == BL) ph = M_DONE;
          end
        end
        default: begin
          rr_model = (w + 1) % N;
          busy[w] = 0;
          bidx[w] = 0;
          txns++;
          ph = M_IDLE;
        end
      endcase
      next_cycle();
    end
    checks++;
    if (txns < 20) begin
      errors++;
      $display("FAIL random_progress txns=%0d min=20", txns);
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    mem_ready = 1'b0;
    idle_inputs();
    test_reset();
    test_single_write();
    test_read_stall();
    test_round_robin();
    test_not_ready();
    test_reset_mid_write();
    test_withdrawn();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
